data_out_collect: RTL and testbench
===================================

DATA_OUT_COLLECT -- requirements
Module: data_out_collect

Interface
REQ-001 Parameter BIT_LENGTH, default `BIT_LENGTH (num_data.v), bits per element.
REQ-002 Parameter DATA_N, default `DATA_N (num_data.v), elements per word; W = BIT_LENGTH*DATA_N.
REQ-003 Parameter FRAME_LEN, default 102, accepted words per frame; legal range 1..65535.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 run  input  1  frame enable; low aborts and clears the frame.
REQ-007 in_valid  input  1  input_data is accepted this cycle when run=1 and in_valid=1.
REQ-008 input_data  input  W  one word; word k of a group goes to slot k.
REQ-009 output_data  output  4*W  registered assembled group; slot 0 in bits [W-1:0], slot 3 in bits [4W-1:3W].
REQ-010 out_valid  output  1  one-cycle pulse: output_data holds a new group.
REQ-011 out_partial  output  1  qualifies out_valid: group is short (end of frame).
REQ-012 frame_done  output  1  one-cycle pulse coincident with the out_valid of the frame's last group.

Function
REQ-013 The block is the inverse of the 4-slot word serializer: it deserializes 4 consecutive W-bit words into one 4W-bit word.
REQ-014 State: slot counter (2 bits, 0..3), frame counter (16 bits, 0..FRAME_LEN-1), 3-slot shadow buffer (3*W).
REQ-015 Accept = run & in_valid; with no accept, counters and buffer hold and out_valid/out_partial/frame_done are 0.
REQ-016 On accept with slot<3 and not last frame word: buffer[slot] <= input_data, slot <= slot+1, frame counter +1.
REQ-017 On accept with slot=3 and not last frame word: output_data <= {input_data, buffer[2], buffer[1], buffer[0]}, out_valid=1 next cycle, out_partial=0, slot <= 0, buffer cleared to 0.
REQ-018 Latency: output_data/out_valid update at the clock edge that accepts the group's final word (visible the following cycle); back-to-back groups can pulse out_valid every 4 accepts.
REQ-019 Last frame word (frame counter = FRAME_LEN-1) accepted: output_data <= current word placed at slot index, lower slots from buffer, higher slots 0; out_valid=1; out_partial=1 unless slot=3; frame_done=1; slot, frame counter, buffer <= 0.
REQ-020 FRAME_LEN=102 yields 25 full groups then one partial group of 2 words (slots 2,3 zero).
REQ-021 FRAME_LEN=1: every accept emits a partial group with slot 0 only, frame_done each accept.
REQ-022 run=0 (any cycle, mid-group or mid-frame): slot, frame counter, buffer, output_data <= 0; out_valid, out_partial, frame_done <= 0; no partial flush.
REQ-023 in_valid ignored while run=0; run re-asserted starts at slot 0, frame word 0.
REQ-024 output_data holds its last value between out_valid pulses while run=1.
REQ-025 Frame counter wraps only via REQ-019; no other overflow path exists.

Reset
REQ-026 rst=1 asynchronously forces output_data=0, out_valid=0, out_partial=0, frame_done=0, slot=0, frame counter=0, buffer=0.
REQ-027 Release of rst takes effect at the next posedge clk; first accepted word goes to slot 0.
REQ-028 rst asserted mid-group discards buffered words; no out_valid is produced for them.

Verification (BIT_LENGTH=4, DATA_N=2, W=8 unless stated)
REQ-029 run=1, in_valid=1, words 0x11,0x22,0x33,0x44 -> one cycle after 4th edge: output_data=0x44332211, out_valid=1 for 1 cycle, out_partial=0.
REQ-030 FRAME_LEN=102, 102 consecutive words 0x01..0x66 -> 25 full pulses, then output_data=0x00006665, out_valid=1, out_partial=1, frame_done=1; next frame starts at slot 0.
REQ-031 Words 0xA1,0xA2 then in_valid=0 for 5 cycles then 0xA3,0xA4 -> output_data=0xA4A3A2A1, single out_valid pulse, none during gap.
REQ-032 Words 0xB1,0xB2,0xB3 then run=0 one cycle, then run=1 with 0xC1..0xC4 -> output_data=0 after drop, then 0xC4C3C2C1, no B-data present.
REQ-033 rst pulsed asynchronously between edges after 2 accepted words -> all outputs 0 immediately; next 4 words 0x01..0x04 -> 0x04030201.
REQ-034 FRAME_LEN=1, words 0x5A,0x5B -> two pulses: 0x0000005A then 0x0000005B, each with out_partial=1, frame_done=1.

Source files
------------

// File: rtl/data_out_collect_if.sv
// Word-stream to group-stream bus for data_out_collect: one W-bit word in,
// one 4W-bit assembled group out with frame qualifiers.
interface data_out_collect_if #(
  parameter int W = 8
);
  logic           run;
  logic           in_valid;
  logic [W-1:0]   input_data;
  logic [4*W-1:0] output_data;
  logic           out_valid;
  logic           out_partial;
  logic           frame_done;

  modport master (
    output run, in_valid, input_data,
    input  output_data, out_valid, out_partial, frame_done
  );

  modport slave (
    input  run, in_valid, input_data,
    output output_data, out_valid, out_partial, frame_done
  );
endinterface

// File: rtl/data_out_collect.sv
// Deserializer: packs 4 consecutive accepted words into one 4W-bit group,
// flushing a short group at the end of each FRAME_LEN-word frame.
module data_out_collect_lane #(
  parameter int W   = 8,
  parameter int IDX = 0
) (
  input  logic [1:0]   slot,
  input  logic [W-1:0] held,
  input  logic [W-1:0] word,
  output logic [W-1:0] lane_out
);
  localparam logic [1:0] I = 2'(IDX);

  // Slots below the current one come from the shadow buffer, the current
  // slot takes the live word, slots above it are empty.
  always_comb begin
    lane_out = '0;
    if (slot > I)       lane_out = held;
    else if (slot == I) lane_out = word;
  end
endmodule

module data_out_collect #(
  parameter int BIT_LENGTH = 4,
  parameter int DATA_N     = 2,
  parameter int FRAME_LEN  = 102
) (
  input  logic clk,
  input  logic rst,
  data_out_collect_if.slave bus
);
  localparam int W     = BIT_LENGTH * DATA_N;
  localparam int SLOTS = 4;
  localparam logic [15:0] LAST = 16'(FRAME_LEN - 1);

  logic [1:0]                  slot;
  logic [15:0]                 frame_cnt;
  logic [SLOTS-2:0][W-1:0]     shadow;
  logic [SLOTS-1:0][W-1:0]     group;
  logic                        accept;
  logic                        last_word;

  assign accept    = bus.run & bus.in_valid;
  assign last_word = (frame_cnt == LAST);

  genvar g;
  generate
    for (g = 0; g < SLOTS; g++) begin : g_lane
      logic [W-1:0] held;
      if (g < SLOTS - 1) begin : g_buf
        assign held = shadow[g];
      end else begin : g_top
        assign held = '0;
      end
      data_out_collect_lane #(.W(W), .IDX(g)) u_lane (
        .slot     (slot),
        .held     (held),
        .word     (bus.input_data),
        .lane_out (group[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot            <= '0;
      frame_cnt       <= '0;
      shadow          <= '0;
      bus.output_data <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_partial <= 1'b0;
      bus.frame_done  <= 1'b0;
    end else if (!bus.run) begin
      // Dropping run abandons the frame outright; buffered words are not flushed.
      slot            <= '0;
      frame_cnt       <= '0;
      shadow          <= '0;
      bus.output_data <= '0;
      bus.out_valid   <= 1'b0;
      bus.out_partial <= 1'b0;
      bus.frame_done  <= 1'b0;
    end else begin
      bus.out_valid   <= 1'b0;
      bus.out_partial <= 1'b0;
      bus.frame_done  <= 1'b0;
      if (accept) begin
        if (last_word) begin
          bus.output_data <= group;
          bus.out_valid   <= 1'b1;
          bus.out_partial <= (slot != 2'd3);
          bus.frame_done  <= 1'b1;
          slot            <= '0;
          frame_cnt       <= '0;
          shadow          <= '0;
        end else if (slot == 2'd3) begin
          bus.output_data <= group;
          bus.out_valid   <= 1'b1;
          slot            <= '0;
          frame_cnt       <= frame_cnt + 16'd1;
          shadow          <= '0;
        end else begin
          for (int k = 0; k < SLOTS - 1; k++)
            if (slot == 2'(k)) shadow[k] <= bus.input_data;
          slot      <= slot + 2'd1;
          frame_cnt <= frame_cnt + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_data_out_collect.sv
// Randomized and directed bench for data_out_collect; two instances
// (FRAME_LEN=102 and FRAME_LEN=1) share stimulus and are checked against a group model.
module tb_data_out_collect;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_out_collect_if #(.W(8)) ia ();
  data_out_collect_if #(.W(8)) ib ();

  data_out_collect #(.BIT_LENGTH(4), .DATA_N(2), .FRAME_LEN(102)) dut_a (
    .clk(clk), .rst(rst), .bus(ia)
  );
  data_out_collect #(.BIT_LENGTH(4), .DATA_N(2), .FRAME_LEN(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ib)
  );

  logic [31:0] o_data [2];
  logic        o_v [2], o_p [2], o_d [2];
  assign o_data[0] = ia.output_data;  assign o_data[1] = ib.output_data;
  assign o_v[0]    = ia.out_valid;    assign o_v[1]    = ib.out_valid;
  assign o_p[0]    = ia.out_partial;  assign o_p[1]    = ib.out_partial;
  assign o_d[0]    = ia.frame_done;   assign o_d[1]    = ib.frame_done;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: words collected for the current group, words seen in frame.
  int          flen [2] = '{102, 1};
  logic [7:0]  gw [2][4];
  int          gn [2];
  int          fcnt [2];
  logic [31:0] m_out [2];
  bit          m_v [2], m_p [2], m_d [2];

  task automatic model_clear();
    for (int j = 0; j < 2; j++) begin
      gn[j] = 0; fcnt[j] = 0; m_out[j] = '0;
      m_v[j] = 0; m_p[j] = 0; m_d[j] = 0;
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [7:0] d);
    ia.run = r; ia.in_valid = v; ia.input_data = d;
    ib.run = r; ib.in_valid = v; ib.input_data = d;
    @(posedge clk);
    for (int j = 0; j < 2; j++) begin
      m_v[j] = 0; m_p[j] = 0; m_d[j] = 0;
      if (!r) begin
        gn[j] = 0; fcnt[j] = 0; m_out[j] = '0;
      end else if (v) begin
        gw[j][gn[j]] = d;
        gn[j]++;
        fcnt[j]++;
        if (gn[j] == 4 || fcnt[j] == flen[j]) begin
          m_out[j] = '0;
          for (int k = 0; k < gn[j]; k++) m_out[j][k*8 +: 8] = gw[j][k];
          m_v[j] = 1;
          m_p[j] = (gn[j] < 4);
          m_d[j] = (fcnt[j] == flen[j]);
          if (fcnt[j] == flen[j]) fcnt[j] = 0;
          gn[j] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int j = 0; j < 2; j++) begin
      n_chk++;
      if ({o_v[j], o_p[j], o_d[j]} !== 3'b000 || o_data[j] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset dut%0d: got v%0b p%0b d%0b %h, want all zero",
                 j, o_v[j], o_p[j], o_d[j], o_data[j]);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] w [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) step(1, 1, w[i]); else step(1, 0, 8'h00);
      for (int j = 0; j < 2; j++) begin
        n_chk++;
        if ({o_v[j], o_p[j], o_d[j]} !== {m_v[j], m_p[j], m_d[j]} || o_data[j] !== m_out[j]) begin
          n_fail++;
          $display("FAIL basic dut%0d cyc%0d: got v%0b p%0b d%0b %h, want v%0b p%0b d%0b %h",
                   j, i, o_v[j], o_p[j], o_d[j], o_data[j], m_v[j], m_p[j], m_d[j], m_out[j]);
        end
      end
      if (i == 3) begin
        n_chk++;
        if (ia.output_data !== 32'h44332211 || ia.out_valid !== 1'b1 || ia.out_partial !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_group: got %h v%0b p%0b, want 44332211 v1 p0",
                   ia.output_data, ia.out_valid, ia.out_partial);
        end
      end
    end
  endtask

  task automatic test_gap();
    int pulses = 0;
    step(0, 0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: step(1, 1, 8'hA1);
        1: step(1, 1, 8'hA2);
        7: step(1, 1, 8'hA3);
        8: step(1, 1, 8'hA4);
        default: step(1, 0, 8'hFF);
      endcase
      if (ia.out_valid === 1'b1) pulses++;
      for (int j = 0; j < 2; j++) begin
        n_chk++;
        if ({o_v[j], o_p[j], o_d[j]} !== {m_v[j], m_p[j], m_d[j]} || o_data[j] !== m_out[j]) begin
          n_fail++;
          $display("FAIL gap dut%0d cyc%0d: got v%0b p%0b d%0b %h, want v%0b p%0b d%0b %h",
                   j, i, o_v[j], o_p[j], o_d[j], o_data[j], m_v[j], m_p[j], m_d[j], m_out[j]);
        end
      end
    end
    n_chk++;
    if (ia.output_data !== 32'hA4A3A2A1 || pulses != 1) begin
      n_fail++;
      $display("FAIL gap_group: got %h pulses %0d, want a4a3a2a1 pulses 1", ia.output_data, pulses);
    end
  endtask

  task automatic test_run_drop();
    logic [7:0] w [8] = '{8'hB1, 8'hB2, 8'hB3, 8'h00, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    for (int i = 0; i < 8; i++) begin
      step(i != 3, i != 3, w[i]);
      for (int j = 0; j < 2; j++) begin
        n_chk++;
        if ({o_v[j], o_p[j], o_d[j]} !== {m_v[j], m_p[j], m_d[j]} || o_data[j] !== m_out[j]) begin
          n_fail++;
          $display("FAIL run_drop dut%0d cyc%0d: got v%0b p%0b d%0b %h, want v%0b p%0b d%0b %h",
                   j, i, o_v[j], o_p[j], o_d[j], o_data[j], m_v[j], m_p[j], m_d[j], m_out[j]);
        end
      end
      if (i == 3) begin
        n_chk++;
        if (ia.output_data !== 32'h0 || ib.output_data !== 32'h0) begin
          n_fail++;
          $display("FAIL run_drop_clear: got %h / %h, want 0", ia.output_data, ib.output_data);
        end
      end
    end
    n_chk++;
    if (ia.output_data !== 32'hC4C3C2C1 || ia.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL run_drop_group: got %h v%0b, want c4c3c2c1 v1", ia.output_data, ia.out_valid);
    end
  endtask

  task automatic test_async_reset();
    step(1, 1, 8'hE1);
    step(1, 1, 8'hE2);
    #2 rst = 1'b1;
    #1;
    model_clear();
    for (int j = 0; j < 2; j++) begin
      n_chk++;
      if ({o_v[j], o_p[j], o_d[j]} !== 3'b000 || o_data[j] !== 32'h0) begin
        n_fail++;
        $display("FAIL async_reset dut%0d: got v%0b p%0b d%0b %h, want all zero",
                 j, o_v[j], o_p[j], o_d[j], o_data[j]);
      end
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 8'(i + 1));
      for (int j = 0; j < 2; j++) begin
        n_chk++;
        if ({o_v[j], o_p[j], o_d[j]} !== {m_v[j], m_p[j], m_d[j]} || o_data[j] !== m_out[j]) begin
          n_fail++;
          $display("FAIL async_reset dut%0d cyc%0d: got v%0b p%0b d%0b %h, want v%0b p%0b d%0b %h",
                   j, i, o_v[j], o_p[j], o_d[j], o_data[j], m_v[j], m_p[j], m_d[j], m_out[j]);
        end
      end
    end
    n_chk++;
    if (ia.output_data !== 32'h04030201 || ia.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_group: got %h v%0b, want 04030201 v1", ia.output_data, ia.out_valid);
    end
  endtask

  task automatic test_frame();
    int full = 0;
    step(0, 0, 8'h00);
    for (int i = 1; i <= 106; i++) begin
      step(1, 1, 8'(i));
      if (i <= 102 && ia.out_valid === 1'b1 && ia.out_partial === 1'b0) full++;
      for (int j = 0; j < 2; j++) begin
        n_chk++;
        if ({o_v[j], o_p[j], o_d[j]} !== {m_v[j], m_p[j], m_d[j]} || o_data[j] !== m_out[j]) begin
          n_fail++;
          $display("FAIL frame dut%0d word%0d: got v%0b p%0b d%0b %h, want v%0b p%0b d%0b %h",
                   j, i, o_v[j], o_p[j], o_d[j], o_data[j], m_v[j], m_p[j], m_d[j], m_out[j]);
        end
      end
      if (i == 102) begin
        n_chk++;
        if (ia.output_data !== 32'h00006665 || {ia.out_valid, ia.out_partial, ia.frame_done} !== 3'b111
            || full != 25) begin
          n_fail++;
          $display("FAIL frame_end: got %h v%0b p%0b d%0b full %0d, want 00006665 v1 p1 d1 full 25",
                   ia.output_data, ia.out_valid, ia.out_partial, ia.frame_done, full);
        end
      end
    end
    n_chk++;
    if (ia.output_data !== 32'h6A696867 || ia.out_partial !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_next: got %h p%0b, want 6a696867 p0", ia.output_data, ia.out_partial);
    end
  endtask

  task automatic test_frame_len1();
    logic [7:0]  w [2] = '{8'h5A, 8'h5B};
    logic [31:0] e [2] = '{32'h0000005A, 32'h0000005B};
    for (int i = 0; i < 2; i++) begin
      step(1, 1, w[i]);
      n_chk++;
      if (ib.output_data !== e[i] || {ib.out_valid, ib.out_partial, ib.frame_done} !== 3'b111) begin
        n_fail++;
        $display("FAIL frame_len1 word%0d: got %h v%0b p%0b d%0b, want %h v1 p1 d1",
                 i, ib.output_data, ib.out_valid, ib.out_partial, ib.frame_done, e[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, 8'($urandom));
      for (int j = 0; j < 2; j++) begin
        n_chk++;
        if ({o_v[j], o_p[j], o_d[j]} !== {m_v[j], m_p[j], m_d[j]} || o_data[j] !== m_out[j]) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d: got v%0b p%0b d%0b %h, want v%0b p%0b d%0b %h",
                   j, i, o_v[j], o_p[j], o_d[j], o_data[j], m_v[j], m_p[j], m_d[j], m_out[j]);
        end
      end
    end
  endtask

  initial begin
    ia.run = 1'b0; ia.in_valid = 1'b0; ia.input_data = '0;
    ib.run = 1'b0; ib.in_valid = 1'b0; ib.input_data = '0;
    model_clear();
    #12;
    test_reset();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_gap();
    test_run_drop();
    test_async_reset();
    test_frame();
    test_frame_len1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
